piso_serializer: RTL



---
 rtl/piso_serializer.sv | 112 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter.
// A WIDTH-bit word is accepted over valid/ready and is sent one bit per bit_en
// strobe on a true/complement pair, with frame_start and frame_end flags.
// Optional macro SER_PARITY_EN appends an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             bit_en,
    output logic             ser_out,
    output logic             ser_out_n,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    // The counter also has to hold the index of the parity bit.
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST_DATA = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
    logic             par;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             advance;
    logic             head;

    assign head    = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign accept  = load_valid & load_ready;
    assign advance = (state != IDLE) & bit_en;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state and all outputs. Outputs come only from registers (plus reset
    // on load_ready), so load_valid has no combinational path to load_ready.
    always_comb begin
        state_nx    = state;
        load_ready  = 1'b0;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                load_ready = ~reset;
                if (accept) state_nx = SHIFT;
            end
            SHIFT: begin
                ser_out     = head;
                ser_valid   = 1'b1;
                busy        = 1'b1;
                frame_start = (cnt == '0);
`ifdef SER_PARITY_EN
                if (bit_en && cnt == LAST_DATA) state_nx = PARITY;
`else
                frame_end   = (cnt == LAST_DATA);
                if (bit_en && cnt == LAST_DATA) state_nx = IDLE;
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                ser_out   = par;
                ser_valid = 1'b1;
                busy      = 1'b1;
                frame_end = 1'b1;
                if (bit_en) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
        ser_out_n = ~ser_out;
    end

    // Datapath: capture on accept, shift the next bit into the head on a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else if (accept) begin
            shreg <= load_data;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= ^load_data;
`endif
        end else if (advance) begin
            shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            cnt   <= (state_nx == IDLE) ? '0 : cnt + CW'(1);
        end
    end

endmodule
